// File: rtl/cache_access_ctrl.sv
// Request sequencer for the cacheSim model: round-robin arbitration, one lookup at a time,
// writeback/fill memory transactions on misses, and hit/miss/writeback statistics.
module cache_access_ctrl #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned ADDRW    = 32,
    parameter int unsigned LINESIZE = 128,
    parameter int unsigned MEMW     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_rw,
    input  logic [NREQ*ADDRW-1:0]   req_addr,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic                    rsp_hit,
    output logic                    cache_lookup,
    output logic                    cache_rw,
    output logic [ADDRW-1:0]        cache_addr,
    input  logic                    cache_hit,
    input  logic                    cache_victim_valid,
    input  logic                    cache_victim_dirty,
    output logic                    cache_fill,
    output logic                    mem_req_valid,
    output logic                    mem_req_we,
    input  logic                    mem_req_ready,
    input  logic                    mem_rsp_valid,
    output logic                    busy,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt,
    output logic [31:0]             wb_cnt
);

    localparam int unsigned BEATS = LINESIZE / MEMW;
    localparam int unsigned IDXW  = $clog2(NREQ);
    localparam int unsigned BCW   = $clog2(BEATS) + 1;

    if (LINESIZE % MEMW != 0) begin : g_bad_linesize
        $fatal(1, "LINESIZE must be a multiple of MEMW");
    end

    typedef enum logic [2:0] {
        StIdle, StLookup, StEval, StWb, StFillReq, StFill, StCommit, StResp
    } state_e;

    state_e           state_q, state_d;
    logic [IDXW-1:0]  rr_q, rr_d;
    logic [IDXW-1:0]  gnt_q, gnt_d;
    logic             rw_q, rw_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic             hit_q, hit_d;
    logic             wb_data_q, wb_data_d;
    logic [BCW-1:0]   beat_q, beat_d;
    logic [31:0]      hit_cnt_q, hit_cnt_d;
    logic [31:0]      miss_cnt_q, miss_cnt_d;
    logic [31:0]      wb_cnt_q, wb_cnt_d;

    logic             gnt_found;
    logic [IDXW-1:0]  gnt_idx;
    logic [IDXW:0]    gnt_inc;
    logic [ADDRW-1:0] addr_sel;
    logic             beat_last;

    assign beat_last = (beat_q == BCW'(BEATS - 1));

    // First valid requester at or after rr_q, wrapping modulo NREQ.
    always_comb begin
        logic [IDXW:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        addr_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_q} + (IDXW+1)'(i);
            if (cand >= (IDXW+1)'(NREQ)) begin
                cand = cand - (IDXW+1)'(NREQ);
            end
            if (!gnt_found && req_valid[cand[IDXW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDXW-1:0];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDXW'(i)) begin
                addr_sel = req_addr[i*ADDRW +: ADDRW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            rr_q       <= '0;
            gnt_q      <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            hit_q      <= 1'b0;
            wb_data_q  <= 1'b0;
            beat_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            hit_q      <= hit_d;
            wb_data_q  <= wb_data_d;
            beat_q     <= beat_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        gnt_d      = gnt_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        hit_d      = hit_q;
        wb_data_d  = wb_data_q;
        beat_d     = beat_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        gnt_inc    = {1'b0, gnt_idx} + 1'b1;
        case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    gnt_d   = gnt_idx;
                    rw_d    = req_rw[gnt_idx];
                    addr_d  = addr_sel;
                    rr_d    = (gnt_inc == (IDXW+1)'(NREQ)) ? '0 : gnt_inc[IDXW-1:0];
                    state_d = StLookup;
                end
            end
            StLookup: state_d = StEval;
            StEval: begin
                hit_d = cache_hit;
                if (cache_hit) begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                    state_d   = StResp;
                end else begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    state_d    = (cache_victim_valid && cache_victim_dirty) ? StWb : StFillReq;
                end
            end
            StWb: begin
                // wb_data_q splits the writeback into its request and data phases.
                if (!wb_data_q) begin
                    if (mem_req_ready) begin
                        wb_data_d = 1'b1;
                        beat_d    = '0;
                    end
                end else if (mem_rsp_valid) begin
                    if (beat_last) begin
                        wb_cnt_d = wb_cnt_q + 32'd1;
                        state_d  = StFillReq;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StFillReq: begin
                if (mem_req_ready) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (mem_rsp_valid) begin
                    if (beat_last) begin
                        state_d = StCommit;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StCommit: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (state_d != state_q) begin
            beat_d    = '0;
            wb_data_d = 1'b0;
        end
    end

    always_comb begin
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_hit       = 1'b0;
        cache_lookup  = 1'b0;
        cache_fill    = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        case (state_q)
            StIdle: begin
                // Gated by reset so no accept pulse leaks out while reset is held.
                if (gnt_found && reset) begin
                    req_ready[gnt_idx] = 1'b1;
                end
            end
            StLookup: cache_lookup = 1'b1;
            StWb: begin
                if (!wb_data_q) begin
                    mem_req_valid = 1'b1;
                    mem_req_we    = 1'b1;
                end
            end
            StFillReq: mem_req_valid = 1'b1;
            StCommit:  cache_fill    = 1'b1;
            StResp: begin
                rsp_valid[gnt_q] = 1'b1;
                rsp_hit          = hit_q;
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != StIdle);
    assign cache_rw   = rw_q;
    assign cache_addr = addr_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;
    assign wb_cnt     = wb_cnt_q;

endmodule

// File: tb/tb_cache_access_ctrl.sv
// Bench for cache_access_ctrl: directed scenarios plus randomized accesses, checked against a
// transaction-level model of round-robin grants, per-access cycle timeline and statistics.
module tb_cache_access_ctrl;

    localparam int NREQ     = 4;
    localparam int ADDRW    = 32;
    localparam int LINESIZE = 128;
    localparam int MEMW     = 32;
    localparam int BEATS    = LINESIZE / MEMW;
    localparam int KHIT     = 0;
    localparam int KCLEAN   = 1;
    localparam int KDIRTY   = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid, req_rw, req_ready, rsp_valid;
    logic [NREQ*ADDRW-1:0] req_addr;
    logic                  rsp_hit, cache_lookup, cache_rw, cache_fill;
    logic [ADDRW-1:0]      cache_addr;
    logic                  cache_hit, cache_victim_valid, cache_victim_dirty;
    logic                  mem_req_valid, mem_req_we, mem_req_ready, mem_rsp_valid, busy;
    logic [31:0]           hit_cnt, miss_cnt, wb_cnt;

    int              tests = 0;
    int              fails = 0;
    int              m_rr = 0;
    int unsigned     m_hit = 0, m_miss = 0, m_wb = 0;
    logic [NREQ-1:0] drop_mask = '0;

    always #5 clk = ~clk;

    cache_access_ctrl #(
        .NREQ(NREQ), .ADDRW(ADDRW), .LINESIZE(LINESIZE), .MEMW(MEMW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
        .cache_lookup(cache_lookup), .cache_rw(cache_rw), .cache_addr(cache_addr),
        .cache_hit(cache_hit), .cache_victim_valid(cache_victim_valid),
        .cache_victim_dirty(cache_victim_dirty), .cache_fill(cache_fill),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .busy(busy),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    // Reference arbiter: first requester holding valid, scanning from the pointer.
    function automatic int model_grant(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_hit = 0; m_miss = 0; m_wb = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_hit"}, rsp_hit, 0);
        check({tag, "_lookup"}, cache_lookup, 0);
        check({tag, "_cache_rw"}, cache_rw, 0);
        check({tag, "_cache_addr"}, cache_addr, 0);
        check({tag, "_cache_fill"}, cache_fill, 0);
        check({tag, "_mem_req_valid"}, mem_req_valid, 0);
        check({tag, "_mem_req_we"}, mem_req_we, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_hit_cnt"}, hit_cnt, 0);
        check({tag, "_miss_cnt"}, miss_cnt, 0);
        check({tag, "_wb_cnt"}, wb_cnt, 0);
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        model_reset();
        reset = 1'b1;
    endtask

    task automatic abort_with_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_state("abort");
        mem_rsp_valid = 1'b1;
        repeat (2) begin
            tick();
            check("abort_fill", cache_fill, 0);
            check("abort_rsp", rsp_valid, 0);
        end
        mem_rsp_valid = 1'b0;
        reset = 1'b1;
    endtask

    // Entered on the first cycle of a memory request; returns after the last beat's edge.
    task automatic mem_phase(input logic we, input int dly, input int gap_max, input int abort_beat,
                             output bit aborted);
        aborted = 1'b0;
        for (int c = 0; c <= dly; c++) begin
            mem_req_ready = (c == dly);
            mem_rsp_valid = 1'($urandom_range(0, 1));
            #1;
            check("mem_req_valid", mem_req_valid, 1);
            check("mem_req_we", mem_req_we, we);
            check("fill_early", cache_fill, 0);
            tick();
        end
        for (int b = 0; b < BEATS; b++) begin
            int gap;
            gap = $urandom_range(0, gap_max);
            for (int c = 0; c < gap; c++) begin
                mem_rsp_valid = 1'b0;
                mem_req_ready = 1'($urandom_range(0, 1));
                #1;
                check("mem_req_drop", mem_req_valid, 0);
                check("fill_early", cache_fill, 0);
                tick();
            end
            mem_rsp_valid = 1'b1;
            #1;
            check("mem_req_drop", mem_req_valid, 0);
            check("fill_early", cache_fill, 0);
            tick();
            mem_rsp_valid = 1'b0;
            if (b + 1 == abort_beat) begin
                abort_with_reset();
                aborted = 1'b1;
                return;
            end
        end
        mem_req_ready = 1'b0;
    endtask

    // One access: the cycle-by-cycle timeline follows from the kind and the delays driven here.
    task automatic do_access(input int kind, input int w_dly, input int f_dly, input int gap_max,
                             input int abort_beat);
        int               g;
        logic [ADDRW-1:0] a;
        logic             rw;
        bit               aborted;
        g  = model_grant(req_valid);
        a  = req_addr[g*ADDRW +: ADDRW];
        rw = req_rw[g];
        #1;
        check("req_ready", req_ready, onehot(g));
        check("busy_idle", busy, 0);
        check("rsp_once", rsp_valid, 0);
        m_rr = (g + 1) % NREQ;
        tick();
        req_valid = req_valid & ~drop_mask;
        req_rw[g] = 1'($urandom_range(0, 1));
        req_addr[g*ADDRW +: ADDRW] = $urandom;
        #1;
        check("lookup", cache_lookup, 1);
        check("cache_addr", cache_addr, a);
        check("cache_rw", cache_rw, rw);
        check("ready_busy", req_ready, 0);
        check("busy", busy, 1);
        tick();
        cache_hit = (kind == KHIT);
        if (kind == KDIRTY) begin
            cache_victim_valid = 1'b1;
            cache_victim_dirty = 1'b1;
        end else if (kind == KCLEAN) begin
            cache_victim_valid = 1'($urandom_range(0, 1));
            cache_victim_dirty = cache_victim_valid ? 1'b0 : 1'($urandom_range(0, 1));
        end else begin
            cache_victim_valid = 1'($urandom_range(0, 1));
            cache_victim_dirty = 1'($urandom_range(0, 1));
        end
        #1;
        check("lookup_once", cache_lookup, 0);
        tick();
        cache_hit          = 1'($urandom_range(0, 1));
        cache_victim_valid = 1'($urandom_range(0, 1));
        cache_victim_dirty = 1'($urandom_range(0, 1));
        if (kind == KHIT) m_hit++;
        else m_miss++;
        aborted = 1'b0;
        if (kind == KDIRTY) begin
            mem_phase(1'b1, w_dly, gap_max, 0, aborted);
            m_wb++;
        end
        if (kind != KHIT) begin
            mem_phase(1'b0, f_dly, gap_max, abort_beat, aborted);
            if (aborted) return;
            #1;
            check("cache_fill", cache_fill, 1);
            check("rsp_early", rsp_valid, 0);
            tick();
        end
        #1;
        check("rsp_valid", rsp_valid, onehot(g));
        check("rsp_hit", rsp_hit, (kind == KHIT));
        check("hit_cnt", hit_cnt, m_hit);
        check("miss_cnt", miss_cnt, m_miss);
        check("wb_cnt", wb_cnt, m_wb);
        check("fill_once", cache_fill, 0);
        check("ready_resp", req_ready, 0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int kinds[8] = '{1, 0, 2, 0, 1, 0, 2, 0};
        reset              = 1'b0;
        req_valid          = '1;
        req_rw             = '0;
        cache_hit          = 1'b0;
        cache_victim_valid = 1'b0;
        cache_victim_dirty = 1'b0;
        mem_req_ready      = 1'b0;
        mem_rsp_valid      = 1'b0;
        for (int i = 0; i < NREQ; i++) req_addr[i*ADDRW +: ADDRW] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        reset = 1'b1;

        // Round-robin over four held reads, all hits.
        for (int i = 0; i < 5; i++) do_access(KHIT, 0, 0, 0, 0);

        // Clean miss, dirty miss, then backpressure with stray beats in the request phase.
        do_access(KCLEAN, 0, 0, 0, 0);
        do_access(KDIRTY, 0, 0, 0, 0);
        do_access(KCLEAN, 0, 5, 0, 0);
        do_access(KDIRTY, 5, 5, 1, 0);

        // Reset after the second fill beat; the next grant restarts at requester 0.
        req_valid = '1;
        do_access(KCLEAN, 0, 0, 0, 2);
        req_valid = '1;
        #1;
        check("post_reset_grant", req_ready, 4'b0001);
        do_access(KHIT, 0, 0, 0, 0);

        // Requester 1 withdraws while 0 is in service and must be skipped.
        reset_dut();
        req_valid = 4'b0011;
        drop_mask = 4'b0010;
        do_access(KHIT, 0, 0, 0, 0);
        drop_mask = '0;
        req_valid = req_valid | 4'b0100;
        #1;
        check("withdrawn_skip", req_ready, 4'b0100);
        do_access(KHIT, 0, 0, 0, 0);

        // Ten accesses since reset, six of them hits.
        req_valid = '1;
        for (int i = 0; i < 8; i++) do_access(kinds[i], 1, 1, 1, 0);
        #1;
        check("stats_hit", hit_cnt, 6);
        check("stats_miss", miss_cnt, 4);
        check("stats_wb", wb_cnt, 2);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = '0;
                for (int c = 0; c < int'($urandom_range(1, 3)); c++) begin
                    #1;
                    check("idle_ready", req_ready, 0);
                    check("idle_busy", busy, 0);
                    tick();
                end
            end
            req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            drop_mask = NREQ'($urandom);
            do_access($urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 4), 2, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_access_ctrl.md
# cache_access_ctrl

Request sequencer for the `cacheSim` model.
- Accepts accesses from `NREQ` requesters and arbitrates them round-robin.
- Issues one lookup at a time to the cache and inspects the hit/victim result.
- On a miss, runs the memory writeback (dirty victim) and line-fill transactions, commits the line, then returns a response to the requester.
- Keeps hit/miss/writeback statistics.
- Sits between the trace-driving requesters and the cache model plus memory port.

## Interface
- `NREQ`, 4, number of requesters (2..16)
- `ADDRW`, 32, address width
- `LINESIZE`, 128, line size in bits
- `MEMW`, 32, memory beat width in bits; `BEATS = LINESIZE/MEMW`; `$fatal` at elaboration if `LINESIZE % MEMW != 0`

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  per-requester access request
- `req_rw`  in  NREQ  per-requester 0 = read, 1 = write
- `req_addr`  in  NREQ*ADDRW  per-requester address, requester i at `[i*ADDRW +: ADDRW]`
- `req_ready`  out  NREQ  one-hot; the accept pulse for the granted requester
- `rsp_valid`  out  NREQ  one-hot; completion pulse
- `rsp_hit`  out  1  hit flag, qualified by `|rsp_valid`
- `cache_lookup`  out  1  lookup strobe
- `cache_rw`  out  1  latched rw
- `cache_addr`  out  ADDRW  latched address
- `cache_hit`  in  1  lookup result, valid the cycle after `cache_lookup`
- `cache_victim_valid`  in  1  victim result, valid the cycle after `cache_lookup`
- `cache_victim_dirty`  in  1  victim result, valid the cycle after `cache_lookup`
- `cache_fill`  out  1  commit-line strobe
- `mem_req_valid`  out  1  memory request
- `mem_req_we`  out  1  1 = writeback, 0 = fill
- `mem_req_ready`  in  1  memory request accept
- `mem_rsp_valid`  in  1  one pulse per completed beat
- `busy`  out  1  high whenever state ≠ IDLE
- `hit_cnt`, `miss_cnt`, `wb_cnt`  out  32 each  statistics counters

## Operation
- FSM states: IDLE, LOOKUP, EVAL, WB, FILL_REQ, FILL, COMMIT, RESP.
- **IDLE**
  - If any `req_valid`, grant the first valid requester at or after `rr_ptr`, wrapping modulo NREQ.
  - Pulse `req_ready[g]` that cycle, latch `g`, `req_rw[g]` and `req_addr[g]`.
  - Set `rr_ptr = (g+1) % NREQ`, then go to LOOKUP.
- **LOOKUP**
  - Assert `cache_lookup` for exactly one cycle, with `cache_addr`/`cache_rw` driven from the latch.
  - Go to EVAL.
- **EVAL**
  - Sample the cache result.
  - Hit: `hit_cnt++`, go to RESP.
  - Miss: `miss_cnt++`. If `cache_victim_valid & cache_victim_dirty`, go to WB; otherwise go to FILL_REQ.
- **WB**
  - Hold `mem_req_valid=1`, `mem_req_we=1` until `mem_req_ready`.
  - Then count BEATS `mem_rsp_valid` pulses with `mem_req_valid=0`.
  - On the last beat: `wb_cnt++`, go to FILL_REQ.
- **FILL_REQ**
  - Hold `mem_req_valid=1`, `mem_req_we=0` until `mem_req_ready`, then go to FILL.
- **FILL**
  - Count BEATS `mem_rsp_valid` pulses.
  - On the last beat, go to COMMIT.
- **COMMIT**
  - `cache_fill=1` for one cycle, then go to RESP.
- **RESP**
  - `rsp_valid[g]=1` for one cycle; `rsp_hit` = the EVAL hit result.
  - Go to IDLE.
- Only one access is outstanding. `req_ready` is 0 outside IDLE.
- A requester that drops `req_valid` before it is granted is simply skipped.
- `mem_rsp_valid` is ignored outside WB-data and FILL. The beat counter is `$clog2(BEATS)+1` bits and clears on each state entry.
- Statistics counters wrap at 2^32. `hit_cnt + miss_cnt` equals the number of completed EVAL cycles.

## Timing
- **Reset:**
  - State = IDLE, `rr_ptr = 0`, all counters 0.
  - All outputs 0: `req_ready`, `rsp_valid`, `rsp_hit`, `cache_*`, `mem_req_*`, `busy`.
  - An assertion mid-transaction aborts immediately; no response is produced and no fill is committed.
- **Hit:** accept at cycle 0, lookup at 1, eval at 2, `rsp_valid` at 3. The next accept is possible at cycle 4.
- **Clean miss**, with `mem_req_ready` high and back-to-back beats:
  - Handshake at cycle 3.
  - Beats at cycles 4..3+BEATS.
  - `cache_fill` at 4+BEATS, `rsp_valid` at 5+BEATS.
- **Dirty miss:** adds 1+BEATS cycles before FILL_REQ.
- **Memory handshake:** `mem_req_valid` stays asserted and stable until `mem_req_ready` is sampled high. The transfer occurs on the cycle both are high.
- **Simultaneous `req_valid`:** exactly one grant per IDLE visit, in round-robin order; the others hold.
- **Grant ordering:** a requester whose request is continuously asserted is granted within NREQ accesses.

## Test plan
- **Round-robin:** reset, then all 4 requesters hold reads → grants go to 0,1,2,3,0 in order, each hit returns `rsp_valid` exactly 3 cycles after `req_ready`.
- **Clean miss:** LINESIZE=128, MEMW=32, `cache_hit=0`, victim invalid, `mem_req_ready=1`, beats back-to-back → `mem_req_we=0`, 4 beats, `cache_fill` at cycle 8, `rsp_valid` at cycle 9 with `rsp_hit=0`, `miss_cnt=1`, `wb_cnt=0`.
- **Dirty miss:** victim valid and dirty → WB request with `we=1`, then 4 beats, then fill request with `we=0` and 4 beats; `wb_cnt=1`; `rsp_valid` at cycle 14.
- **Backpressure:** hold `mem_req_ready=0` for 5 cycles → `mem_req_valid` stays high and stable; stray `mem_rsp_valid` pulses during the request phase do not advance the beat count.
- **Reset mid-FILL:** drop `reset` after beat 2 → all outputs go to 0 asynchronously, no `cache_fill` or `rsp_valid` is produced, counters read 0, and the next grant goes to requester 0.
- **Withdrawn request and stats:** requester 1 drops `req_valid` while requester 0 is in service → requester 1 is not granted. Run 10 mixed accesses (6 hits) → `hit_cnt=6`, `miss_cnt=4`.
